// File: rtl/multicycle_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB timing,
// per-state strobes, memory-ready handshake with timeout trap, retire count.
//
// Ports:
//   clk, rst (sync, active-high), hold (freeze + strobe suppress)
//   opcode[5:0], branch_taken, mem_ready       -> inputs
//   mem_req, mem_we, iord, ir_write, mdr_write,
//   pc_write, pc_src[1:0], alu_en, reg_write,
//   link_sel, instr_done                       -> combinational strobes
//   halted, illegal_op, mem_timeout, state[2:0],
//   retired[CNT_W-1:0]                         -> registered status
module multicycle_sequencer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic [5:0]       opcode,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             mdr_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             alu_en,
  output logic             reg_write,
  output logic             link_sel,
  output logic             instr_done,
  output logic             halted,
  output logic             illegal_op,
  output logic             mem_timeout,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  localparam int WCW = $clog2(MEM_TIMEOUT);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_BNE  = 6'b000001;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BLT  = 6'b000011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BGE  = 6'b000101;
  localparam logic [5:0] OP_JAL  = 6'b000110;
  localparam logic [5:0] OP_JR   = 6'b000111;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SUBI = 6'b001001;
  localparam logic [5:0] OP_LWI  = 6'b001010;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_NOP  = 6'b111111;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t         cur, nxt;
  logic [WCW-1:0] wcnt;
  logic           set_ill, set_to;
  logic           is_alu, is_br, is_lw, is_sw, is_jal;
  logic           waiting, expired;

  assign is_alu = (opcode == OP_R)    || (opcode == OP_ADDI) ||
                  (opcode == OP_SUBI) || (opcode == OP_LWI);
  assign is_br  = (opcode == OP_BEQ)  || (opcode == OP_BNE)  ||
                  (opcode == OP_BLT)  || (opcode == OP_BGE);
  assign is_lw  = (opcode == OP_LW);
  assign is_sw  = (opcode == OP_SW);
  assign is_jal = (opcode == OP_JAL);

  // Waiting on memory: the cycle counts toward the timeout.
  assign waiting = ((cur == S_FETCH) || (cur == S_MEM)) && !mem_ready;
  assign expired = waiting && (wcnt == WCW'(MEM_TIMEOUT - 1));

  always_comb begin
    nxt        = cur;
    set_ill    = 1'b0;
    set_to     = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    mdr_write  = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    alu_en     = 1'b0;
    reg_write  = 1'b0;
    link_sel   = 1'b0;
    instr_done = 1'b0;
    case (cur)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          nxt      = S_DECODE;
        end else if (expired) begin
          set_to = 1'b1;
          nxt    = S_HALT;
        end
      end
      S_DECODE: begin
        unique case (1'b1)
          (opcode == OP_NOP): begin
            instr_done = 1'b1;
            nxt        = S_FETCH;
          end
          (opcode == OP_J): begin
            pc_write   = 1'b1;
            pc_src     = 2'b01;
            instr_done = 1'b1;
            nxt        = S_FETCH;
          end
          (opcode == OP_JR): begin
            pc_write   = 1'b1;
            pc_src     = 2'b10;
            instr_done = 1'b1;
            nxt        = S_FETCH;
          end
          (is_alu || is_br || is_lw || is_sw || is_jal): begin
            nxt = S_EXEC;
          end
          default: begin
            set_ill = 1'b1;
            nxt     = S_HALT;
          end
        endcase
      end
      S_EXEC: begin
        alu_en = 1'b1;
        unique case (1'b1)
          is_alu: nxt = S_WB;
          (is_lw || is_sw): nxt = S_MEM;
          is_br: begin
            pc_write   = branch_taken;
            pc_src     = 2'b11;
            instr_done = 1'b1;
            nxt        = S_FETCH;
          end
          is_jal: begin
            reg_write  = 1'b1;
            link_sel   = 1'b1;
            pc_write   = 1'b1;
            pc_src     = 2'b01;
            instr_done = 1'b1;
            nxt        = S_FETCH;
          end
          default: begin
            // Opcode changed under us after DECODE.
            set_ill = 1'b1;
            nxt     = S_HALT;
          end
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = is_sw;
        if (mem_ready) begin
          if (is_lw) begin
            mdr_write = 1'b1;
            nxt       = S_WB;
          end else begin
            instr_done = 1'b1;
            nxt        = S_FETCH;
          end
        end else if (expired) begin
          set_to = 1'b1;
          nxt    = S_HALT;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        nxt        = S_FETCH;
      end
      default: nxt = S_HALT;
    endcase
    if (rst || hold) begin
      nxt        = cur;
      set_ill    = 1'b0;
      set_to     = 1'b0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      iord       = 1'b0;
      ir_write   = 1'b0;
      mdr_write  = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 2'b00;
      alu_en     = 1'b0;
      reg_write  = 1'b0;
      link_sel   = 1'b0;
      instr_done = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur         <= S_FETCH;
      wcnt        <= '0;
      retired     <= '0;
      illegal_op  <= 1'b0;
      mem_timeout <= 1'b0;
    end else begin
      cur <= nxt;
      // Any non-waiting cycle clears, so entry to FETCH/MEM sees 0.
      if (!hold) begin
        wcnt <= waiting ? wcnt + WCW'(1) : '0;
      end
      if (set_ill) illegal_op <= 1'b1;
      if (set_to) mem_timeout <= 1'b1;
      if (instr_done) retired <= retired + CNT_W'(1);
    end
  end

  assign state  = cur;
  assign halted = (cur == S_HALT);

endmodule
